// File: rtl/stream_pkg.sv
// Shared types and constants for the block-transfer stream engine.
package stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IN    = 2'd1,
    OUT   = 2'd2,
    DRAIN = 2'd3
  } stream_state_t;

  localparam logic STREAM_DIR_IN  = 1'b0;
  localparam logic STREAM_DIR_OUT = 1'b1;

endpackage

// File: rtl/stream_control_if.sv
// Command, inbound/outbound word streams and memory-port request signals of stream_control.
interface stream_control_if #(
  parameter int MAIN_ADDR_WIDTH = 16,
  parameter int WORD_WIDTH      = 32,
  parameter int COUNT_WIDTH     = 16
);
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic                       cmd_dir;
  logic [MAIN_ADDR_WIDTH-1:0] cmd_address;
  logic [COUNT_WIDTH-1:0]     cmd_count;

  logic                       in_valid;
  logic                       in_ready;
  logic [WORD_WIDTH-1:0]      in_value;

  logic                       out_valid;
  logic                       out_ready;
  logic [WORD_WIDTH-1:0]      out_value;

  logic                       stream_in;
  logic                       stream_out;
  logic [MAIN_ADDR_WIDTH-1:0] stream_address;
  logic [WORD_WIDTH-1:0]      stream_in_value;
  logic                       stream_grant;
  logic [WORD_WIDTH-1:0]      mem_read_value;

  logic                       abort;
  logic                       busy;
  logic                       done;

  modport slave (
    input  cmd_valid, cmd_dir, cmd_address, cmd_count,
    input  in_valid, in_value, out_ready,
    input  stream_grant, mem_read_value, abort,
    output cmd_ready, in_ready, out_valid, out_value,
    output stream_in, stream_out, stream_address, stream_in_value,
    output busy, done
  );

  modport master (
    output cmd_valid, cmd_dir, cmd_address, cmd_count,
    output in_valid, in_value, out_ready,
    output stream_grant, mem_read_value, abort,
    input  cmd_ready, in_ready, out_valid, out_value,
    input  stream_in, stream_out, stream_address, stream_in_value,
    input  busy, done
  );
endinterface

// File: rtl/stream_out_fifo.sv
// Two-entry synchronous FIFO holding read words until the outbound port accepts them.
module stream_out_fifo #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic [WORD_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [1:0]            o_count,
  output logic [WORD_WIDTH-1:0] o_head
);
  logic [WORD_WIDTH-1:0] r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + 2'(i_push) - 2'(i_pop);
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
endmodule

// File: rtl/stream_control.sv
// Block-transfer engine: moves words between a valid/ready port and main memory, one per granted cycle.
module stream_control
  import stream_pkg::*;
#(
  parameter int MAIN_ADDR_WIDTH = 16,
  parameter int WORD_WIDTH      = 32,
  parameter int COUNT_WIDTH     = 16
) (
  input logic             clk,
  input logic             reset,
  stream_control_if.slave bus
);
  stream_state_t              r_state;
  stream_state_t              w_state_nxt;
  logic [MAIN_ADDR_WIDTH-1:0] r_addr;
  logic [COUNT_WIDTH-1:0]     r_count;
  logic [WORD_WIDTH-1:0]      r_buf;
  logic                       r_buf_full;
  logic                       r_pending;
  logic                       r_done;
  logic                       w_done_nxt;

  logic                       w_abort;
  logic                       w_accept;
  logic                       w_last;
  logic                       w_wr_grant;
  logic                       w_rd_req;
  logic                       w_rd_grant;
  logic                       w_in_ready;
  logic                       w_in_fire;
  logic                       w_pop;
  logic                       w_push;
  logic                       w_fifo_empty_nxt;
  logic [1:0]                 w_fifo_count;
  logic [1:0]                 w_occupancy;
  logic [WORD_WIDTH-1:0]      w_fifo_head;

  assign w_abort    = bus.abort && (r_state != IDLE);
  assign w_accept   = (r_state == IDLE) && bus.cmd_valid;
  assign w_last     = (r_count == COUNT_WIDTH'(1));
  assign w_wr_grant = (r_state == IN) && r_buf_full && bus.stream_grant;

  // A pending read already owns a FIFO slot, so it counts toward the two-word limit.
  assign w_occupancy = w_fifo_count + {1'b0, r_pending};
  assign w_rd_req    = (r_state == OUT) && (r_count != '0) && (w_occupancy < 2'd2);
  assign w_rd_grant  = w_rd_req && bus.stream_grant;

  // Never accept more words than remain; a granted write frees the buffer in the same cycle.
  assign w_in_ready = (r_state == IN) && !bus.abort &&
                      ((r_count - COUNT_WIDTH'(r_buf_full)) != '0) &&
                      (!r_buf_full || bus.stream_grant);
  assign w_in_fire  = bus.in_valid && w_in_ready;

  assign w_pop            = bus.out_ready && (w_fifo_count != 2'd0);
  assign w_push           = r_pending && !w_abort;
  assign w_fifo_empty_nxt = (w_fifo_count == 2'd0) || ((w_fifo_count == 2'd1) && w_pop);

  stream_out_fifo #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_out_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_abort),
    .i_push  (w_push),
    .i_data  (bus.mem_read_value),
    .i_pop   (w_pop),
    .o_count (w_fifo_count),
    .o_head  (w_fifo_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_count == '0) begin
            w_done_nxt = 1'b1;
          end else if (bus.cmd_dir == STREAM_DIR_OUT) begin
            w_state_nxt = OUT;
          end else begin
            w_state_nxt = IN;
          end
        end
      end
      IN: begin
        if (w_wr_grant && w_last) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      OUT: begin
        if (w_rd_grant && w_last) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!r_pending && w_fifo_empty_nxt) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = IDLE;
      w_done_nxt  = 1'b0;
    end
  end

  // An aborted grant still reaches memory, but address/count stay put and its read data is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_count    <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_pending  <= 1'b0;
    end else if (w_abort) begin
      r_buf_full <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= bus.cmd_address;
        r_count <= bus.cmd_count;
      end
      if (w_wr_grant || w_rd_grant) begin
        r_addr  <= r_addr + MAIN_ADDR_WIDTH'(1);
        r_count <= r_count - COUNT_WIDTH'(1);
      end
      if (w_in_fire) begin
        r_buf      <= bus.in_value;
        r_buf_full <= 1'b1;
      end else if (w_wr_grant) begin
        r_buf_full <= 1'b0;
      end
      r_pending <= w_rd_grant;
    end
  end

  assign bus.cmd_ready       = (r_state == IDLE);
  assign bus.busy            = (r_state != IDLE);
  assign bus.done            = r_done;
  assign bus.in_ready        = w_in_ready;
  assign bus.out_valid       = (w_fifo_count != 2'd0);
  assign bus.out_value       = w_fifo_head;
  assign bus.stream_in       = (r_state == IN) && r_buf_full;
  assign bus.stream_out      = w_rd_req;
  assign bus.stream_address  = r_addr;
  assign bus.stream_in_value = r_buf;
endmodule

// File: doc/stream_control.md
# stream_control

Stream engine feeding the core's memory controller through its `stream_in`, `stream_out`, `stream_address` and `stream_in_value` inputs. Accepts a block-transfer command (base address, word count, direction) and moves words between an external valid/ready port and main memory, one word per granted cycle. Memory access is opportunistic: the core grants the port only in cycles where the current instruction leaves it idle.

## Interface
Parameters:
- `MAIN_ADDR_WIDTH`, 16, main memory word-address width
- `WORD_WIDTH`, 32, data word width
- `COUNT_WIDTH`, 16, transfer length counter width

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: sole clock, all state on rising edge
- `reset` in 1: synchronous, active-high
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake
- `cmd_dir` in 1: 0 = stream in (external→memory), 1 = stream out (memory→external)
- `cmd_address` in MAIN_ADDR_WIDTH: first word address
- `cmd_count` in COUNT_WIDTH: words to move
- `in_valid` in 1 / `in_ready` out 1 / `in_value` in WORD_WIDTH: inbound words
- `out_valid` out 1 / `out_ready` in 1 / `out_value` out WORD_WIDTH: outbound words
- `stream_in` out 1: write request to memory controller
- `stream_out` out 1: read request to memory controller
- `stream_address` out MAIN_ADDR_WIDTH: request address
- `stream_in_value` out WORD_WIDTH: write data
- `stream_grant` in 1: memory controller honours the asserted request this cycle
- `mem_read_value` in WORD_WIDTH: read data, valid the cycle after a granted `stream_out`
- `abort` in 1: terminate current transfer
- `busy` out 1: state ≠ IDLE
- `done` out 1: one-cycle pulse on normal completion

## Operation
- States: IDLE, IN, OUT, DRAIN.
- IDLE: `cmd_ready`=1. On `cmd_valid`: latch address, count, dir. count=0 → stay IDLE, `done` next cycle. Otherwise → IN (dir 0) or OUT (dir 1).
- IN: one-word buffer `buf`. `stream_in`=`buf_full`; `stream_address`=current address; `stream_in_value`=`buf`. Grant → address+1, count−1, buffer empties. `in_ready` = (count − `buf_full`) ≠ 0 and (!`buf_full` or `stream_grant`); same-cycle drain and refill allowed. Grant with count=1 → IDLE, `done`.
- OUT: 2-entry FIFO `stream_out_fifo`. `stream_out` = count≠0 and (FIFO occupancy + pending read) < 2. Grant → address+1, count−1, pending set; next cycle `mem_read_value` pushed, pending cleared. `out_valid` = FIFO non-empty, `out_value` = head. count reaches 0 → DRAIN.
- DRAIN: no requests; pending read still captured. Pending clear and FIFO empty → IDLE, `done`.
- `stream_in` and `stream_out` never both high; both 0 outside IN/OUT. `stream_grant` without a request is ignored.
- Address wraps modulo 2^MAIN_ADDR_WIDTH; count width is not checked against address space.
- `abort` (any non-IDLE state): → IDLE next cycle, buffer and FIFO flushed, in-flight read data discarded, no `done`. Ignored in IDLE.
- `abort` with a same-cycle grant: memory access still occurs (controller already committed); counters not updated.

## Timing
- Reset: state IDLE; `cmd_ready`=1; `in_ready`, `out_valid`, `stream_in`, `stream_out`, `busy`, `done`=0; `stream_address`, `stream_in_value`, `out_value`=0; buffer, FIFO, pending cleared. Reset mid-transfer behaves like abort plus full clear.
- Command accept → first request: 1 cycle (IN also needs a buffered word).
- IN sustains 1 word/cycle under continuous grant and `in_valid`.
- OUT: grant in cycle N → word in FIFO, `out_valid` at N+2 edge view (pushed at end of N+1); 1 word/cycle under continuous grant and `out_ready`.
- `done` pulses the cycle after the final grant (IN) or the final FIFO pop (OUT); `cmd_ready` high in that same cycle.
- `stream_*` outputs are registered-state functions only; no combinational path from `stream_grant` to `stream_*`. `in_ready` depends combinationally on `stream_grant`.

## Structure
- Package `stream_pkg`: state enum typedef `stream_state_t` (IDLE, IN, OUT, DRAIN), constants `STREAM_DIR_IN`=0, `STREAM_DIR_OUT`=1.
- Sub-module `stream_out_fifo`: 2-entry synchronous FIFO (push, pop, count, head), parameterised by WORD_WIDTH.

## Test plan
- IN, address 0x0010, count 3, words A,B,C, grant always → writes 0x0010=A, 0x0011=B, 0x0012=C on consecutive cycles, `done` once.
- OUT, address 0x0100, count 4, grant every other cycle, `out_ready` low 5 cycles → ≤2 reads outstanding+stored, all 4 words delivered in order, `done` after last pop.
- Command count 0 → no stream request, `done` next cycle, `busy` never high.
- OUT from 0xFFFF, count 2 → addresses 0xFFFF then 0x0000.
- Abort in OUT with one read pending, FIFO holding 1 → next cycle IDLE, `out_valid`=0, late `mem_read_value` not emitted, no `done`.
- Reset asserted mid IN transfer with buffered word → all outputs at reset values next cycle; new command accepted cleanly.
